// File: rtl/openip_fifo_slice.sv
// Circular-buffer FIFO slice between valid/ready stages, with optional fall-through,
// synchronous flush, fill level and almost-full flag. w_ready never depends on r_ready.
module openip_fifo_slice #(
    parameter int  DATA_WIDTH   = 1,
    parameter type TYPE         = logic [DATA_WIDTH-1:0],
    parameter int  DEPTH        = 2,
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  AF_THRESH    = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  TYPE                        w_data,
    output logic                       r_valid,
    input  logic                       r_ready,
    output TYPE                        r_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] LAST_P = PTR_W'(DEPTH - 1);

    TYPE              mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             store;
    logic             stored_pop;

    // Pointers wrap explicitly so any DEPTH works, not just powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty      = (count == '0);
        full       = (count == FULL_C);
        bypass     = FALL_THROUGH && empty;
        w_ready    = rstn && !full && !flush;
        r_valid    = rstn && !flush && (!empty || (bypass && w_valid));
        r_data     = bypass ? w_data : mem[rd_ptr];
        push       = w_valid && w_ready;
        pop        = r_valid && r_ready;
        stored_pop = pop && !empty;
        // A beat popped while the buffer is empty went straight through; never store it.
        store      = push && !(empty && pop);
        count_nxt  = count;
        if (store && !stored_pop) begin
            count_nxt = count + 1'b1;
        end else if (!store && stored_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (stored_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count       <= count_nxt;
            almost_full <= (count_nxt >= AF_C);
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= w_data;
        end
    end

`ifndef SYNTHESIS
    a_wdata_stable : assert property (@(posedge clk) disable iff (!rstn)
        (w_valid && !w_ready) |=> $stable(w_data));
    a_no_push_full : assert property (@(posedge clk) disable iff (!rstn)
        push |-> (count != FULL_C));
    a_count_range : assert property (@(posedge clk) disable iff (!rstn)
        count <= FULL_C);
    a_af_range : assert property (@(posedge clk)
        (AF_THRESH >= 1) && (AF_THRESH <= DEPTH));
`endif

endmodule
